// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//   Time-setting controller for the HH:MM:SS clock datapath. Mode key walks
//   RUN -> SET_HH -> SET_MM -> SET_SS -> RUN; increment key bumps the field
//   being edited in a private BCD snapshot. Leaving SET_SS with the mode key
//   issues a one-cycle load of the snapshot. An idle timeout in any set state
//   abandons the edit and returns to RUN without a load.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   key_mode     : debounced mode key, 1-cycle pulse
//   key_inc      : debounced increment key, 1-cycle pulse
//   time_in      : live BCD time {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}
//   run_en       : 1 = counter may advance, 0 = hold
//   load_en      : 1-cycle strobe, counter loads load_time
//   load_time    : edited BCD time (meaningful while load_en=1)
//   blink_mask   : per-digit blank flags, bit5=hh_t .. bit0=ss_u
//   mode_state   : 0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_SS
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int BLINK_HALF   = 25_000_000,
  parameter int IDLE_TIMEOUT = 500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic [23:0] time_in,
  output logic        run_en,
  output logic        load_en,
  output logic [23:0] load_time,
  output logic [5:0]  blink_mask,
  output logic [1:0]  mode_state
);

  localparam int CNT_MAX = (BLINK_HALF > IDLE_TIMEOUT) ? BLINK_HALF : IDLE_TIMEOUT;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   edit_q, edit_d;
  logic          load_en_q, load_en_d;
  logic [23:0]   load_time_q, load_time_d;
  logic [5:0]    blink_mask_q, blink_mask_d;
  logic          run_en_q, run_en_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          key_any;

  // BCD +1 with wrap. Any value at/above the limit, or with a non-BCD
  // nibble, wraps to 00 so a corrupted snapshot can always be recovered.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= lim) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign key_any = key_mode | key_inc;

  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    load_en_d   = 1'b0;
    load_time_d = load_time_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    idle_cnt_d  = idle_cnt_q;

    // Mode always takes precedence; a coincident increment is dropped.
    case (state_q)
      ST_RUN: begin
        if (key_mode) begin
          edit_d  = time_in;
          state_d = ST_SET_HH;
        end
      end
      ST_SET_HH: begin
        if (key_mode)     state_d = ST_SET_MM;
        else if (key_inc) edit_d[23:16] = bcd_inc(edit_q[23:16], 8'h23);
      end
      ST_SET_MM: begin
        if (key_mode)     state_d = ST_SET_SS;
        else if (key_inc) edit_d[15:8] = bcd_inc(edit_q[15:8], 8'h59);
      end
      ST_SET_SS: begin
        if (key_mode) begin
          state_d     = ST_RUN;
          load_en_d   = 1'b1;
          load_time_d = edit_q;
        end else if (key_inc) begin
          edit_d[7:0] = bcd_inc(edit_q[7:0], 8'h59);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Abandon the edit after a long stretch with no key activity.
    if (state_q != ST_RUN && !key_any && idle_cnt_q == IDLE_LAST) begin
      state_d = ST_RUN;
    end

    // Any key or state change restarts both timers with digits shown, so
    // the user sees the result of an edit immediately.
    if (state_d == ST_RUN || key_any || state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      idle_cnt_d  = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    run_en_d = (state_d == ST_RUN);

    blink_mask_d = 6'b000000;
    if (phase_d) begin
      case (state_d)
        ST_SET_HH: blink_mask_d = 6'b110000;
        ST_SET_MM: blink_mask_d = 6'b001100;
        ST_SET_SS: blink_mask_d = 6'b000011;
        default:   blink_mask_d = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      edit_q       <= '0;
      load_en_q    <= 1'b0;
      load_time_q  <= '0;
      blink_mask_q <= '0;
      run_en_q     <= 1'b1;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      load_en_q    <= load_en_d;
      load_time_q  <= load_time_d;
      blink_mask_q <= blink_mask_d;
      run_en_q     <= run_en_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign run_en     = run_en_q;
  assign load_en    = load_en_q;
  assign load_time  = load_time_q;
  assign blink_mask = blink_mask_q;
  assign mode_state = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic [23:0] time_in = 24'h0;
  logic        run_en;
  logic        load_en;
  logic [23:0] load_time;
  logic [5:0]  blink_mask;
  logic [1:0]  mode_state;

  clock_set_ctrl #(.BLINK_HALF(4), .IDLE_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc),
    .time_in(time_in), .run_en(run_en), .load_en(load_en),
    .load_time(load_time), .blink_mask(blink_mask), .mode_state(mode_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        i;
    logic [23:0] tin;
    logic [1:0]  st;
    logic        run;
    logic        ld;
    logic [23:0] lt;
    logic [5:0]  mask;
    string       name;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic m, input logic i, input logic [23:0] tin,
                              input logic [1:0] st, input logic run, input logic ld,
                              input logic [23:0] lt, input logic [5:0] mask, input string name);
    vec_t v;
    v.m = m; v.i = i; v.tin = tin; v.st = st; v.run = run; v.ld = ld;
    v.lt = lt; v.mask = mask; v.name = name;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of stimulus (called just after a rising edge), queue
  // the expectation, then compare just after the next rising edge.
  task automatic step(input vec_t v);
    vec_t e;
    key_mode = v.m;
    key_inc  = v.i;
    time_in  = v.tin;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".state"}, {30'd0, mode_state}, {30'd0, e.st});
    chk({e.name, ".run_en"}, {31'd0, run_en}, {31'd0, e.run});
    chk({e.name, ".load_en"}, {31'd0, load_en}, {31'd0, e.ld});
    chk({e.name, ".mask"}, {26'd0, blink_mask}, {26'd0, e.mask});
    if (e.ld) chk({e.name, ".load_time"}, {8'd0, load_time}, {8'd0, e.lt});
    $display("step %-10s m=%0b i=%0b st=%0d run=%0b ld=%0b lt=%06h mask=%06b",
             e.name, v.m, v.i, mode_state, run_en, load_en, load_time, blink_mask);
  endtask

  task automatic run_table();
    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);
    tbl.delete();
  endtask

  task automatic check_reset(input string name);
    chk({name, ".state"}, {30'd0, mode_state}, 32'd0);
    chk({name, ".run_en"}, {31'd0, run_en}, 32'd1);
    chk({name, ".load_en"}, {31'd0, load_en}, 32'd0);
    chk({name, ".load_time"}, {8'd0, load_time}, 32'd0);
    chk({name, ".mask"}, {26'd0, blink_mask}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: entry to SET_HH and blink cadence
    add(1, 0, 24'h235958, 1, 0, 0, 0, 6'b000000, "enter_hh");
    for (int k = 1; k <= 8; k++)
      add(0, 0, 24'h0, 1, 0, 0, 0, ((k / 4) % 2) ? 6'b110000 : 6'b000000, $sformatf("blink%0d", k));
    // 2: hours 23 wraps to 00, then exit and confirm
    add(0, 1, 24'h0, 1, 0, 0, 0, 6'b000000, "hh23_inc");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    add(1, 0, 24'h0, 3, 0, 0, 0, 6'b000000, "to_ss");
    add(1, 0, 24'h0, 0, 1, 1, 24'h005958, 6'b000000, "load_23");
    add(0, 0, 24'h0, 0, 1, 0, 0, 6'b000000, "after_ld");
    add(0, 1, 24'h0, 0, 1, 0, 0, 6'b000000, "run_inc");
    // 09 -> 10
    add(1, 0, 24'h091011, 1, 0, 0, 0, 6'b000000, "enter_09");
    add(0, 1, 24'h0, 1, 0, 0, 0, 6'b000000, "hh09_inc");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    add(1, 0, 24'h0, 3, 0, 0, 0, 6'b000000, "to_ss");
    add(1, 0, 24'h0, 0, 1, 1, 24'h101011, 6'b000000, "load_09");
    // 3: full pass from 12:34:56; time_in changes during set are ignored
    add(1, 0, 24'h123456, 1, 0, 0, 0, 6'b000000, "enter_12");
    add(0, 1, 24'h999999, 1, 0, 0, 0, 6'b000000, "hh_inc1");
    add(0, 1, 24'h000000, 1, 0, 0, 0, 6'b000000, "hh_inc2");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    add(0, 1, 24'h0, 2, 0, 0, 0, 6'b000000, "mm_inc");
    add(1, 0, 24'h0, 3, 0, 0, 0, 6'b000000, "to_ss");
    add(1, 0, 24'h0, 0, 1, 1, 24'h143556, 6'b000000, "load_full");
    add(0, 0, 24'h0, 0, 1, 0, 0, 6'b000000, "one_shot");
    run_table();

    // 4: idle timeout in SET_MM
    add(1, 0, 24'h111111, 1, 0, 0, 0, 6'b000000, "enter_to");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    run_table();
    for (int k = 1; k <= 31; k++) begin
      v.m = 0; v.i = 0; v.tin = 0; v.st = 2; v.run = 0; v.ld = 0; v.lt = 0;
      v.mask = ((k / 4) % 2) ? 6'b001100 : 6'b000000;
      v.name = $sformatf("idle%0d", k);
      step(v);
    end
    v.st = 0; v.run = 1; v.mask = 0; v.name = "timeout";
    step(v);
    v.name = "post_to";
    step(v);

    // 5: simultaneous keys at minutes 59, seconds wrap from 59
    add(1, 0, 24'h125958, 1, 0, 0, 0, 6'b000000, "enter_59");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    add(1, 1, 24'h0, 3, 0, 0, 0, 6'b000000, "both_keys");
    add(0, 1, 24'h0, 3, 0, 0, 0, 6'b000000, "ss58_inc");
    add(0, 1, 24'h0, 3, 0, 0, 0, 6'b000000, "ss59_inc");
    add(1, 0, 24'h0, 0, 1, 1, 24'h125900, 6'b000000, "load_59");
    // 6: drop into SET_SS for the reset test
    add(1, 0, 24'h010203, 1, 0, 0, 0, 6'b000000, "enter_rst");
    add(1, 0, 24'h0, 2, 0, 0, 0, 6'b000000, "to_mm");
    add(1, 0, 24'h0, 3, 0, 0, 0, 6'b000000, "to_ss");
    run_table();

    // Reset mid-cycle: outputs must clear before any clock edge
    key_mode = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    key_mode = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset("rst_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
